// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell processes a WIDTH-bit addition LSB first,
// one bit per clock, reporting sum, carry-out and signed overflow with a done pulse.

module structuralFullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic axb;
    logic gen;
    logic prop;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign gen  = a & b;
    assign prop = axb & cin;
    assign cout = gen | prop;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_c;

    structuralFullAdder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (cnt == LAST);
    assign ready    = (state == IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_reg <= carryin;
                        cnt       <= '0;
                        sum       <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    sum       <= {fa_s, sum[WIDTH-1:1]};
                    carry_reg <= fa_c;
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    if (last_bit) begin
                        // carry_reg here is the carry into the MSB.
                        carryout <= fa_c;
                        overflow <= carry_reg ^ fa_c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
